// File: rtl/plic_gateway_bank.sv
// Bank of PLIC interrupt gateways: synchronizes raw device lines, tracks per-source
// pending/in-flight state and retires requests through the claim/complete handshake.
module plic_gateway_bank #(
  parameter int NSRC        = 8,
  parameter int IDW         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNTW        = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] io_src,
  input  logic [NSRC-1:0] io_edge,
  input  logic            io_claim_valid,
  input  logic [IDW-1:0]  io_claim_id,
  input  logic            io_complete_valid,
  input  logic [IDW-1:0]  io_complete_id,
  output logic [NSRC-1:0] io_ip,
  output logic [NSRC-1:0] io_inflight,
  output logic            io_drop
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_reg;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_prev_reg;
  logic [NSRC-1:0] edge_evt;
  logic [NSRC-1:0] ip_reg;
  logic [NSRC-1:0] ip_next;
  logic [NSRC-1:0] inflight_reg;
  logic [NSRC-1:0] inflight_next;
  logic [NSRC-1:0] drop_vec;
  logic            drop_reg;

  assign s        = sync_reg[SYNC_STAGES-1];
  assign edge_evt = s & ~s_prev_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg   <= '0;
      s_prev_reg <= '0;
    end else begin
      sync_reg[0] <= io_src;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
      s_prev_reg <= s;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic            claim_hit;
      logic            complete_hit;
      logic            drop_hit;
      logic [CNTW-1:0] cnt_reg;
      logic [CNTW-1:0] cnt_next;

      // Only a pending source can be claimed and only an in-flight one completed,
      // so a same-ID claim+complete can never both be accepted.
      assign claim_hit    = io_claim_valid && (io_claim_id == IDW'(gi + 1)) && ip_reg[gi];
      assign complete_hit = io_complete_valid && (io_complete_id == IDW'(gi + 1)) &&
                            inflight_reg[gi];

      always_comb begin
        cnt_next = cnt_reg;
        drop_hit = 1'b0;
        if (!io_edge[gi]) begin
          cnt_next = '0;
        end else if (edge_evt[gi] && !claim_hit) begin
          if (cnt_reg == CNT_MAX) begin
            drop_hit = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (!edge_evt[gi] && claim_hit && (cnt_reg != '0)) begin
          // cnt can be 0 with ip set right after a level-to-edge switch; never wrap
          cnt_next = cnt_reg - 1'b1;
        end
      end

      assign inflight_next[gi] = claim_hit | (inflight_reg[gi] & ~complete_hit);
      assign ip_next[gi]       = ~inflight_next[gi] &
                                 (io_edge[gi] ? (cnt_next != '0) : s[gi]);
      assign drop_vec[gi]      = drop_hit;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ip_reg       <= '0;
      inflight_reg <= '0;
      drop_reg     <= 1'b0;
    end else begin
      ip_reg       <= ip_next;
      inflight_reg <= inflight_next;
      drop_reg     <= |drop_vec;
    end
  end

  assign io_ip       = ip_reg;
  assign io_inflight = inflight_reg;
  assign io_drop     = drop_reg;

endmodule

// File: tb/tb_plic_gateway_bank.sv
// Directed and randomized checks of plic_gateway_bank against a per-source
// arithmetic model (delay-line synchronizer, integer edge counts).
module tb_plic_gateway_bank;
  localparam int NSRC = 8;
  localparam int IDW  = 4;
  localparam int SS   = 2;
  localparam int CNTW = 3;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic [NSRC-1:0] edge_m = '0;
  logic            cv = 1'b0;
  logic [IDW-1:0]  cid = '0;
  logic            pv = 1'b0;
  logic [IDW-1:0]  pid = '0;
  logic [NSRC-1:0] ip;
  logic [NSRC-1:0] infl;
  logic            drop;

  always #5 clk = ~clk;

  plic_gateway_bank #(.NSRC(NSRC), .IDW(IDW), .SYNC_STAGES(SS), .CNTW(CNTW)) dut (
    .clock(clk), .reset(rst_n), .io_src(src), .io_edge(edge_m),
    .io_claim_valid(cv), .io_claim_id(cid),
    .io_complete_valid(pv), .io_complete_id(pid),
    .io_ip(ip), .io_inflight(infl), .io_drop(drop)
  );

  int total = 0;
  int bad = 0;
  int drop_seen = 0;

  logic [NSRC-1:0] hist[$];
  int              m_cnt[NSRC];
  logic [NSRC-1:0] m_ip, m_inf;
  logic            m_drop;

  task automatic model_clear();
    hist = {};
    repeat (SS + 1) hist.push_front('0);
    for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
    m_ip = '0; m_inf = '0; m_drop = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_step();
    logic [NSRC-1:0] s, sp, nip, ninf;
    logic nd;
    int n, ev, ck, cp;
    if (!rst_n) begin
      model_clear();
      return;
    end
    s  = hist[SS-1];
    sp = hist[SS];
    nd = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      ev = (s[i] && !sp[i]) ? 1 : 0;
      ck = (cv && int'(cid) == i + 1 && m_ip[i]) ? 1 : 0;
      cp = (pv && int'(pid) == i + 1 && m_inf[i]) ? 1 : 0;
      ninf[i] = (ck == 1) ? 1'b1 : ((cp == 1) ? 1'b0 : m_inf[i]);
      if (edge_m[i]) begin
        n = m_cnt[i] + ev - ck;
        if (n > CMAX) begin n = CMAX; nd = 1'b1; end
        if (n < 0) n = 0;
      end else begin
        n = 0;
      end
      m_cnt[i] = n;
      nip[i] = !ninf[i] && (edge_m[i] ? (n != 0) : s[i]);
    end
    m_ip = nip; m_inf = ninf; m_drop = nd;
    hist.push_front(src);
    void'(hist.pop_back());
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (drop === 1'b1) drop_seen++;
    chk("ip", 32'(ip), 32'(m_ip));
    chk("inflight", 32'(infl), 32'(m_inf));
    chk("drop", 32'(drop), 32'(m_drop));
  endtask

  task automatic claim(int id);
    cv = 1'b1; cid = IDW'(id); tick(); cv = 1'b0;
  endtask

  task automatic complete(int id);
    pv = 1'b1; pid = IDW'(id); tick(); pv = 1'b0;
  endtask

  task automatic pulse(int i);
    src[i] = 1'b1; tick(); src[i] = 1'b0; tick();
  endtask

  initial begin
    model_clear();
    repeat (2) tick();
    chk("rst_ip", 32'(ip), 0);
    chk("rst_inflight", 32'(infl), 0);
    chk("rst_drop", 32'(drop), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ip", 32'(ip), 0);

    // Level source ID 3
    src[2] = 1'b1;
    tick(); tick();
    chk("lvl_lat2", 32'(ip), 32'h00);
    tick();
    chk("lvl_lat3", 32'(ip), 32'h04);
    claim(3);
    chk("lvl_claim_ip", 32'(ip), 32'h00);
    chk("lvl_claim_inf", 32'(infl), 32'h04);
    complete(3);
    chk("lvl_rearm_ip", 32'(ip), 32'h04);
    chk("lvl_rearm_inf", 32'(infl), 32'h00);
    src[2] = 1'b0;
    repeat (3) tick();
    chk("lvl_fall", 32'(ip), 32'h00);

    // Edge source ID 1: three edges, three claim/complete rounds
    edge_m[0] = 1'b1;
    repeat (3) pulse(0);
    repeat (3) tick();
    chk("edge_pend", 32'(ip), 32'h01);
    for (int k = 0; k < 3; k++) begin
      claim(1);
      chk("edge_claim_ip", 32'(ip), 32'h00);
      chk("edge_claim_inf", 32'(infl), 32'h01);
      complete(1);
      chk("edge_rearm", 32'(ip), (k < 2) ? 32'h01 : 32'h00);
    end

    // Saturation: 9 edges, count stops at 7 with two drops
    drop_seen = 0;
    repeat (9) pulse(0);
    repeat (3) tick();
    chk("sat_drops", 32'(drop_seen), 2);
    for (int k = 0; k < CMAX; k++) begin
      claim(1);
      complete(1);
      chk("sat_drain", 32'(ip), (k < CMAX - 1) ? 32'h01 : 32'h00);
    end

    // Illegal handshakes with ID2 pending and ID5 in flight
    src[1] = 1'b1; src[4] = 1'b1;
    repeat (3) tick();
    chk("ill_setup_ip", 32'(ip), 32'h12);
    claim(5);
    chk("ill_setup_inf", 32'(infl), 32'h10);
    claim(0);
    chk("ill_id0_ip", 32'(ip), 32'h02);
    chk("ill_id0_inf", 32'(infl), 32'h10);
    claim(9);
    chk("ill_id9_ip", 32'(ip), 32'h02);
    claim(4);
    chk("ill_nonpend_ip", 32'(ip), 32'h02);
    chk("ill_nonpend_inf", 32'(infl), 32'h10);
    complete(2);
    chk("ill_cmpl_ip", 32'(ip), 32'h02);
    chk("ill_cmpl_inf", 32'(infl), 32'h10);
    chk("ill_drop", 32'(drop), 0);

    // Concurrency: claim 2 with complete 5
    cv = 1'b1; cid = 4'd2; pv = 1'b1; pid = 4'd5;
    tick();
    cv = 1'b0; pv = 1'b0;
    chk("conc_ip", 32'(ip), 32'h10);
    chk("conc_inf", 32'(infl), 32'h02);
    // Edge on ID1 arriving in the same cycle as its claim, cnt = 1
    pulse(0);
    repeat (2) tick();
    chk("conc_cnt1_ip", 32'(ip), 32'h11);
    src[0] = 1'b1; tick();
    src[0] = 1'b0; tick();
    claim(1);
    chk("conc_edge_claim_ip", 32'(ip), 32'h10);
    chk("conc_edge_claim_inf", 32'(infl), 32'h03);
    complete(1);
    chk("conc_cnt_kept_ip", 32'(ip), 32'h11);
    claim(1);
    complete(1);
    chk("conc_cnt_drained", 32'(ip), 32'h10);

    // Reset mid-flight with ID5 in flight and cnt[0] = 5
    claim(5);
    chk("mid_inf", 32'(infl), 32'h12);
    repeat (5) pulse(0);
    repeat (2) tick();
    src = 8'h10;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_ip", 32'(ip), 0);
    chk("mid_rst_inf", 32'(infl), 0);
    chk("mid_rst_drop", 32'(drop), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rearm_lat2", 32'(ip), 32'h00);
    tick();
    chk("rearm_lat3", 32'(ip), 32'h10);
    chk("rearm_inf", 32'(infl), 32'h00);
    repeat (4) tick();
    chk("cnt_cleared", 32'(ip), 32'h10);

    // Randomized traffic against the model
    edge_m = 8'h0F;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) edge_m = NSRC'($urandom);
      src = src ^ NSRC'($urandom & $urandom & $urandom);
      cv  = 1'($urandom_range(0, 2) == 0);
      cid = IDW'($urandom_range(0, 10));
      pv  = 1'($urandom_range(0, 2) == 0);
      pid = IDW'($urandom_range(0, 10));
      tick();
    end
    cv = 1'b0; pv = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
